// File: rtl/alarm_trigger.sv
// alarm_trigger: alarm-time comparator and ring controller; snooze logic is built only when ALARM_SNOOZE_EN is defined
module alarm_trigger #(
    parameter int unsigned SNOOZE_S       = 300,
    parameter int unsigned RING_TIMEOUT_S = 600,
    parameter int unsigned MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [4:0] cur_hr,
    input  logic [5:0] cur_min,
    input  logic [4:0] alm_hr,
    input  logic [5:0] alm_min,
    input  logic       alarm_en,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       alarm,
    output logic [1:0] state,
    output logic [1:0] snooze_used
);
    typedef enum logic [1:0] {DISARMED = 2'd0, ARMED = 2'd1, RINGING = 2'd2, SNOOZED = 2'd3} state_t;
    localparam logic [9:0] RING_LOAD = 10'(RING_TIMEOUT_S);
    state_t     state_q, state_d;
    logic       match, match_q, match_rise;
    logic [9:0] ring_q, ring_d;
    logic       ring_exp, alarm_q;
    logic       snz_go, snz_exp;
    logic [1:0] used_q;
    assign match      = (cur_hr == alm_hr) && (cur_min == alm_min) && (alm_hr <= 5'd23) && (alm_min <= 6'd59);
    assign match_rise = match && !match_q;
    assign ring_exp   = sec_tick && (ring_q <= 10'd1);
`ifdef ALARM_SNOOZE_EN
    localparam logic [9:0] SNZ_LOAD = 10'(SNOOZE_S);
    localparam logic [1:0] MAX_U    = 2'(MAX_SNOOZE);
    logic [9:0] snz_q, snz_d;
    logic [1:0] used_d;
    assign snz_go  = snooze_btn && (used_q < MAX_U);
    assign snz_exp = sec_tick && (snz_q <= 10'd1);
    // snooze countdown and per-event snooze tally, driven by the state transitions taken
    always_comb begin
        used_d = (state_q == ARMED && state_d == RINGING) ? 2'd0 :
                 (state_q == RINGING && state_d == SNOOZED) ? used_q + 2'd1 : used_q;
        snz_d  = (state_q == RINGING && state_d == SNOOZED) ? SNZ_LOAD :
                 (state_q == SNOOZED && sec_tick && snz_q != 10'd0) ? snz_q - 10'd1 : snz_q;
    end
    // snooze registers
    always_ff @(posedge clk) begin
        if (rst) begin
            snz_q  <= '0;
            used_q <= '0;
        end else begin
            snz_q  <= snz_d;
            used_q <= used_d;
        end
    end
`else
    logic unused_snooze;
    assign unused_snooze = ^{snooze_btn, SNOOZE_S != 0, MAX_SNOOZE != 0};
    assign snz_go        = 1'b0;
    assign snz_exp       = 1'b0;
    assign used_q        = 2'd0;
`endif
    // next-state and ring counter: disarm beats stop beats snooze beats expiry beats match
    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        if (!alarm_en) begin
            state_d = DISARMED;
        end else begin
            case (state_q)
                DISARMED: state_d = ARMED;
                ARMED: begin
                    if (!stop_btn && match_rise) begin
                        state_d = RINGING;
                        ring_d  = RING_LOAD;
                    end
                end
                RINGING: begin
                    state_d = stop_btn ? ARMED : snz_go ? SNOOZED : ring_exp ? ARMED : RINGING;
                    ring_d  = (sec_tick && ring_q != 10'd0) ? ring_q - 10'd1 : ring_q;
                end
                SNOOZED: begin
                    if (stop_btn) begin
                        state_d = ARMED;
                    end else if (snz_exp) begin
                        state_d = RINGING;
                        ring_d  = RING_LOAD;
                    end
                end
                default: state_d = DISARMED;
            endcase
        end
    end
    // state, ring counter, match history and registered ring request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DISARMED;
            ring_q  <= '0;
            match_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            match_q <= match;
            alarm_q <= (state_d == RINGING);
        end
    end
    assign alarm       = alarm_q;
    assign state       = state_q;
    assign snooze_used = used_q;
endmodule
